hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Detects load-use hazards that the forwarding logic cannot cover. Sequences branch-flush penalty cycles. Freezes the pipeline while data memory is busy.
- Drives PC/IF-ID write enables, IF-ID flush, ID-EX bubble insertion and EX-MEM/MEM-WB hold.
- Sits beside the forwarding unit in the ID/EX boundary logic.

Parameters:
- REG_W, 5, register-index width.
- NULL_REG, 5'b11111, index meaning "no destination". Never matches as a hazard source.
- FLUSH_CYCLES, 1, IF-ID flush cycles per taken branch. Range 1..7.
- MEM_TIMEOUT, 255, MEM_WAIT cycles before the sticky timeout flag sets. Must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  REG_W  ID-stage source register 1
- id_rt  in  REG_W  ID-stage source register 2
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_rd  in  REG_W  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX (single-cycle pulse per branch)
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF-ID register enable
- ifid_flush  out  1  IF-ID register clears to NOP
- idex_bubble  out  1  ID-EX register loads NOP
- back_hold  out  1  EX-MEM and MEM-WB hold
- mem_timeout  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = RUN, flush_cnt = 0, wait_cnt = 0, mem_timeout = 0.
  - Control outputs decode to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, back_hold=0.
- Reset assertion mid-sequence aborts any stall or flush immediately, with no residual effect.
- Control outputs are combinational from (state, inputs). State, counters and mem_timeout are registered.
- Definitions:
  - load_use = ex_mem_read && ex_rd != NULL_REG && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt)).
  - mem_stall = mem_req && !mem_ready.
- Priority: mem_stall > ex_branch_taken > load_use.
- State RUN:
  - mem_stall: pc_write=0, ifid_write=0, back_hold=1, idex_bubble=0. Next state MEM_WAIT. wait_cnt <= 1.
  - Else ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1 (PC loads target). If FLUSH_CYCLES > 1, next state FLUSH and flush_cnt <= FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else load_use: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN; the bubble clears the hazard the next cycle.
  - Else: all enables 1, flush and bubble 0.
- State MEM_WAIT:
  - Same outputs as the RUN mem_stall case while mem_stall.
  - wait_cnt increments and saturates. mem_timeout sets when wait_cnt == MEM_TIMEOUT and stays set until reset.
  - On mem_ready: outputs as RUN for that cycle (normal advance). Next state RUN. wait_cnt <= 0.
  - ex_branch_taken and load_use are ignored while frozen; they are re-evaluated in RUN because the frozen inputs persist.
- State FLUSH:
  - ifid_flush=1, pc_write=1, idex_bubble=0. flush_cnt decrements; at 1, next state RUN.
  - mem_stall in FLUSH: back_hold=1, pc_write=0, ifid_flush held. flush_cnt does not decrement.
  - A new ex_branch_taken in FLUSH reloads flush_cnt to FLUSH_CYCLES-1.
- Simultaneous events:
  - load_use and ex_branch_taken in the same cycle: branch wins, and the bubble squashes the load-use consumer.
  - mem_ready arriving in the first mem_req cycle: no stall at all.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN. When defined, adds three outputs:
  - load_stall_cnt (16-bit): cycles with load_use stall.
  - mem_stall_cnt (16-bit): cycles with back_hold=1.
  - flush_cnt_total (16-bit): cycles with ifid_flush=1.
- Each counter saturates at 16'hFFFF and resets to 0 on rst_n.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg: state enum (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2), NULL_REG constant, REG_W constant, control-bundle typedef {pc_write, ifid_write, ifid_flush, idex_bubble, back_hold}.
- One sub-module: hazard_detect, a purely combinational load_use comparator reused by the top-level decode.

Test Plan:
- Reset: rst_n=0 for 3 cycles with arbitrary inputs -> pc_write=1, ifid_write=1, other controls 0, mem_timeout=0. Assert rst_n=0 mid-FLUSH (FLUSH_CYCLES=3) -> outputs return to RUN values in the same cycle.
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1. With id_rt=8, id_uses_rt=0 and id_rs≠8 -> no stall. With ex_rd=31 -> no stall.
- Branch: FLUSH_CYCLES=3, ex_branch_taken pulse -> ifid_flush=1 for 3 consecutive cycles, idex_bubble=1 only in the first. A second taken pulse in cycle 2 -> flush extends to 2 more cycles after it.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> back_hold=1 and pc_write=0 for 4 cycles, normal on the 5th. mem_ready=1 in the first cycle -> no hold.
- Timeout: MEM_TIMEOUT=5, mem_ready held 0 for 10 cycles -> mem_timeout rises after the 5th wait cycle and stays 1 after mem_ready returns, until rst_n.
- Priority: mem_stall, ex_branch_taken and load_use together -> freeze only. After mem_ready, with the branch input still asserted -> flush begins, and no load-use bubble separate from the branch bubble.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared constants, state enum and control bundle (package hazard_pkg)
package hazard_pkg;

  localparam int               REG_W    = 5;
  localparam logic [REG_W-1:0] NULL_REG = 5'b11111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic back_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                     idex_bubble: 1'b0, back_hold: 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b0, back_hold: 1'b1};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline-side hazard inputs and stall/flush controls
// Perf-counter signals appear only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_controller_if
  import hazard_pkg::*;
  ();

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             back_hold;
  logic             mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]      load_stall_cnt;
  logic [15:0]      mem_stall_cnt;
  logic [15:0]      flush_cnt_total;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, back_hold, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
         , load_stall_cnt, mem_stall_cnt, flush_cnt_total
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, back_hold, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
         , load_stall_cnt, mem_stall_cnt, flush_cnt_total
`endif
  );

endinterface

// File: rtl/hazard_stall_controller_detect.sv
// rtl/hazard_stall_controller_detect.sv - combinational load-use hazard comparator (hazard_detect)
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int           W        = REG_W,
  parameter logic [W-1:0] NULL_IDX = NULL_REG
) (
  input  logic         ex_mem_read_i,
  input  logic [W-1:0] ex_rd_i,
  input  logic [W-1:0] id_rs_i,
  input  logic [W-1:0] id_rt_i,
  input  logic         id_uses_rt_i,
  output logic         load_use_o
);

  // A load targeting the null index writes nothing, so it can never be a hazard source.
  assign load_use_o = ex_mem_read_i
                   && (ex_rd_i != NULL_IDX)
                   && ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use stall, branch flush and memory freeze sequencing
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hazard_stall_controller_if.slave  hz
);

  localparam int                WAIT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX     = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE     = WAIT_W'(1);
  localparam logic [2:0]        FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic              load_use;
  logic              mem_stall;
  ctrl_t             ctrl;
  ctrl_t             ctrl_out;
`ifdef HAZARD_PERF_CNT_EN
  logic              load_stall;
  logic [15:0]       load_stall_cnt_q;
  logic [15:0]       mem_stall_cnt_q;
  logic [15:0]       flush_total_q;
`endif

  hazard_detect #(
    .W        (REG_W),
    .NULL_IDX (NULL_REG)
  ) u_detect (
    .ex_mem_read_i (hz.ex_mem_read),
    .ex_rd_i       (hz.ex_rd),
    .id_rs_i       (hz.id_rs),
    .id_rt_i       (hz.id_rt),
    .id_uses_rt_i  (hz.id_uses_rt),
    .load_use_o    (load_use)
  );

  assign mem_stall = hz.mem_req && !hz.mem_ready;

  // RUN and MEM_WAIT share one decode: once memory completes, MEM_WAIT advances exactly like RUN.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    ctrl        = CTRL_ADVANCE;
`ifdef HAZARD_PERF_CNT_EN
    load_stall  = 1'b0;
`endif
    if (state_q == FLUSH) begin
      ctrl.ifid_flush = 1'b1;
      if (mem_stall) begin
        ctrl.pc_write  = 1'b0;
        ctrl.back_hold = 1'b1;
      end else if (hz.ex_branch_taken) begin
        flush_cnt_d = FLUSH_RELOAD;
      end else if (flush_cnt_q <= 3'd1) begin
        state_d     = RUN;
        flush_cnt_d = 3'd0;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end else if (mem_stall) begin
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        wait_cnt_d = WAIT_ONE;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end
      if (wait_cnt_d == WAIT_MAX) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (hz.ex_branch_taken) begin
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_RELOAD;
        end
      end else if (load_use) begin
        ctrl.pc_write    = 1'b0;
        ctrl.ifid_write  = 1'b0;
        ctrl.idex_bubble = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
        load_stall       = 1'b1;
`endif
      end
    end
  end

  // Controls fall back to free-running values the instant reset is asserted.
  assign ctrl_out = rst_n ? ctrl : CTRL_ADVANCE;

  assign hz.pc_write    = ctrl_out.pc_write;
  assign hz.ifid_write  = ctrl_out.ifid_write;
  assign hz.ifid_flush  = ctrl_out.ifid_flush;
  assign hz.idex_bubble = ctrl_out.idex_bubble;
  assign hz.back_hold   = ctrl_out.back_hold;
  assign hz.mem_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt_q <= 16'd0;
      mem_stall_cnt_q  <= 16'd0;
      flush_total_q    <= 16'd0;
    end else begin
      load_stall_cnt_q <= sat_inc16(load_stall_cnt_q, load_stall);
      mem_stall_cnt_q  <= sat_inc16(mem_stall_cnt_q, ctrl.back_hold);
      flush_total_q    <= sat_inc16(flush_total_q, ctrl.ifid_flush);
    end
  end

  assign hz.load_stall_cnt  = load_stall_cnt_q;
  assign hz.mem_stall_cnt   = mem_stall_cnt_q;
  assign hz.flush_cnt_total = flush_total_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;

  localparam int F = 3;
  localparam int T = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_controller_if hz();

  hazard_stall_controller #(
    .FLUSH_CYCLES (F),
    .MEM_TIMEOUT  (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  logic [4:0] s_rs, s_rt, s_rd;
  logic       s_urt, s_mr, s_br, s_mreq, s_mrdy, s_rstn;

  logic [5:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  // Reference model: remaining flush cycles, consecutive frozen cycles, sticky flag.
  int         m_flush_left = 0;
  int         m_waited     = 0;
  bit         m_to         = 1'b0;

  function automatic logic [5:0] model_step();
    logic pc, ifw, fl, bub, bh, to;
    bit   lu, ms;
    pc = 1'b1; ifw = 1'b1; fl = 1'b0; bub = 1'b0; bh = 1'b0;
    if (!s_rstn) begin
      m_flush_left = 0;
      m_waited     = 0;
      m_to         = 1'b0;
      return 6'b110000;
    end
    to = m_to;
    lu = s_mr && (s_rd != 5'd31) && ((s_rd == s_rs) || (s_urt && (s_rd == s_rt)));
    ms = s_mreq && !s_mrdy;
    if (m_flush_left > 0) begin
      fl = 1'b1;
      if (ms) begin
        bh = 1'b1;
        pc = 1'b0;
      end else if (s_br) begin
        m_flush_left = F - 1;
      end else begin
        m_flush_left = m_flush_left - 1;
      end
    end else if (ms) begin
      pc = 1'b0; ifw = 1'b0; bh = 1'b1;
      m_waited = (m_waited == 0) ? 1 : ((m_waited + 1 > T) ? T : m_waited + 1);
      if (m_waited == T) m_to = 1'b1;
    end else begin
      m_waited = 0;
      if (s_br) begin
        fl = 1'b1; bub = 1'b1;
        m_flush_left = F - 1;
      end else if (lu) begin
        pc = 1'b0; ifw = 1'b0; bub = 1'b1;
      end
    end
    return {pc, ifw, fl, bub, bh, to};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    rst_n              = s_rstn;
    hz.id_rs           = s_rs;
    hz.id_rt           = s_rt;
    hz.id_uses_rt      = s_urt;
    hz.ex_rd           = s_rd;
    hz.ex_mem_read     = s_mr;
    hz.ex_branch_taken = s_br;
    hz.mem_req         = s_mreq;
    hz.mem_ready       = s_mrdy;
    exp_q.push_back(model_step());
  endtask

  task automatic idle();
    s_rs = 5'd1; s_rt = 5'd2; s_rd = 5'd0; s_urt = 1'b1; s_mr = 1'b0;
    s_br = 1'b0; s_mreq = 1'b0; s_mrdy = 1'b1; s_rstn = 1'b1;
  endtask

  function automatic logic [4:0] rnd_reg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 5'd31 : 5'(v);
  endfunction

  initial begin : monitor
    logic [5:0] e, act;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.back_hold, hz.mem_timeout};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL ctrl @cycle %0d: got %b want %b (pc_write,ifid_write,ifid_flush,idex_bubble,back_hold,mem_timeout)",
                   cyc, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.ex_rd = '0; hz.ex_mem_read = 1'b0;
    hz.ex_branch_taken = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    idle();

    for (int i = 0; i < 3; i++) begin
      s_rs = rnd_reg(); s_rt = rnd_reg(); s_rd = rnd_reg(); s_urt = 1'($urandom);
      s_mr = 1'b1; s_br = 1'($urandom); s_mreq = 1'b1; s_mrdy = 1'b0; s_rstn = 1'b0;
      tick();
    end
    idle(); tick(); tick();

    s_mr = 1'b1; s_rd = 5'd8; s_rs = 5'd8; tick();
    idle(); tick();
    s_mr = 1'b1; s_rd = 5'd8; s_rt = 5'd8; s_urt = 1'b0; s_rs = 5'd3; tick();
    s_urt = 1'b1; tick();
    idle(); s_mr = 1'b1; s_rd = 5'd31; s_rs = 5'd31; s_rt = 5'd31; tick();
    idle(); tick();

    s_br = 1'b1; tick();
    s_br = 1'b0; repeat (4) tick();
    s_br = 1'b1; tick();
    s_br = 1'b0; tick();
    s_br = 1'b1; tick();
    s_br = 1'b0; repeat (4) tick();

    s_mreq = 1'b1; s_mrdy = 1'b0; repeat (4) tick();
    s_mrdy = 1'b1; tick();
    s_mreq = 1'b0; tick();
    s_mreq = 1'b1; s_mrdy = 1'b1; tick();
    s_mreq = 1'b0; tick();

    s_mreq = 1'b1; s_mrdy = 1'b0; repeat (10) tick();
    s_mrdy = 1'b1; tick();
    idle(); repeat (3) tick();

    s_mreq = 1'b1; s_mrdy = 1'b0; s_br = 1'b1; s_mr = 1'b1; s_rd = 5'd8; s_rs = 5'd8;
    repeat (3) tick();
    s_mrdy = 1'b1; tick();
    s_mreq = 1'b0; s_br = 1'b0; repeat (3) tick();

    idle(); s_br = 1'b1; tick();
    s_br = 1'b0; tick();
    s_rstn = 1'b0; tick();
    s_rstn = 1'b1; tick(); tick();

    for (int i = 0; i < 3000; i++) begin
      s_rs   = rnd_reg();
      s_rt   = rnd_reg();
      s_rd   = rnd_reg();
      s_urt  = 1'($urandom);
      s_mr   = ($urandom_range(0, 1) == 0);
      s_br   = ($urandom_range(0, 5) == 0);
      s_mreq = ($urandom_range(0, 2) == 0);
      s_mrdy = ($urandom_range(0, 3) == 0);
      s_rstn = ($urandom_range(0, 299) != 0);
      tick();
    end

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
